psum_ofifo: RTL and testbench

// Output FIFO directly downstream of the MAC array. It captures per-column partial sums as each

---
 rtl/psum_ofifo.sv | 100 ++++++++++
 tb/tb_psum_ofifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_ofifo.sv
// psum_ofifo: output FIFO behind the MAC array.
// Each column is pushed independently as its psum arrives (skewed by the
// wavefront). All columns share one read pointer, so a pop always returns
// one re-aligned row of col partial sums.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);

  // Pointers carry one extra wrap bit so that full and empty are distinguishable.
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int PW = AW + 1;

  logic [PW-1:0]          r_wrPtr [col];
  logic [PW-1:0]          r_rdPtr;
  logic [psum_bw-1:0]     r_mem   [col][depth];
  logic [psum_bw*col-1:0] r_out;
  logic                   r_ovf;

  logic [PW-1:0]          w_count [col];
  logic [col-1:0]         w_empty;
  logic [col-1:0]         w_full;
  logic [col-1:0]         w_push;
  logic [col-1:0]         w_drop;
  logic                   w_valid;
  logic                   w_pop;

  // Per-column occupancy and write qualification, all judged from pre-edge pointers.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_push  = '0;
    w_drop  = '0;
    for (int c = 0; c < col; c++) begin
      w_count[c] = r_wrPtr[c] - r_rdPtr;
      w_empty[c] = (w_count[c] == '0);
      w_full[c]  = (w_count[c] == PW'(depth));
      w_push[c]  = wr[c] & ~w_full[c];
      w_drop[c]  = wr[c] & w_full[c];
    end
  end

  assign w_valid = &(~w_empty);
  assign w_pop   = rd & w_valid;

  assign out     = r_out;
  assign o_valid = w_valid;
  assign o_full  = |w_full;
  assign o_ready = ~(|w_full);
  assign o_ovf   = r_ovf;

  // Pointer advance, registered row output and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < col; c++) begin
        r_wrPtr[c] <= '0;
      end
      r_rdPtr <= '0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        if (w_push[c]) begin
          r_wrPtr[c] <= r_wrPtr[c] + PW'(1);
        end
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
        for (int c = 0; c < col; c++) begin
          r_out[c*psum_bw +: psum_bw] <= r_mem[c][r_rdPtr[AW-1:0]];
        end
      end
      if (|w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage array; no reset needed since pointers gate every read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wrPtr[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
      end
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// Testbench for psum_ofifo: queue-based reference model plus scoreboard.
module tb_psum_ofifo;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int RW    = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [RW-1:0] in = '0;
  logic [COL-1:0] wr = '0;
  logic          rd = 1'b0;
  logic [RW-1:0] out;
  logic          o_valid;
  logic          o_full;
  logic          o_ready;
  logic          o_ovf;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one plain queue per column, expected rows for the scoreboard.
  logic [BW-1:0] colQ [COL][$];
  logic [RW-1:0] expQ [$];
  logic [RW-1:0] lastRow = '0;
  bit            modelOvf = 1'b0;

  psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [RW-1:0] actual, input logic [RW-1:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, required);
    end
  endtask

  function automatic bit modelValid();
    for (int c = 0; c < COL; c++) if (colQ[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit modelFull();
    for (int c = 0; c < COL; c++) if (colQ[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [RW-1:0] randRow();
    logic [RW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'($urandom);
    return r;
  endfunction

  // Flags and held row against the model state left by the previous edge.
  task automatic checkOutput();
    compare("o_valid", RW'(o_valid), RW'(modelValid()));
    compare("o_full",  RW'(o_full),  RW'(modelFull()));
    compare("o_ready", RW'(o_ready), RW'(!modelFull()));
    compare("o_ovf",   RW'(o_ovf),   RW'(modelOvf));
    compare("out_hold", out, lastRow);
  endtask

  // Advance the model by one clock edge using the inputs just applied.
  task automatic modelStep(input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
    bit v;
    bit f [COL];
    logic [RW-1:0] row;
    v = modelValid();
    for (int c = 0; c < COL; c++) f[c] = (colQ[c].size() == DEPTH);
    if (r && v) begin
      for (int c = 0; c < COL; c++) row[c*BW +: BW] = colQ[c].pop_front();
      expQ.push_back(row);
      lastRow = row;
    end
    for (int c = 0; c < COL; c++) begin
      if (w[c]) begin
        if (!f[c]) colQ[c].push_back(d[c*BW +: BW]);
        else modelOvf = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
    @(negedge clk);
    checkOutput();
    wr = w;
    in = d;
    rd = r;
    modelStep(w, d, r);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic resetDut();
    @(negedge clk);
    wr = '0;
    rd = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    compare("rst_out",     out, '0);
    compare("rst_o_valid", RW'(o_valid), RW'(0));
    compare("rst_o_full",  RW'(o_full),  RW'(0));
    compare("rst_o_ready", RW'(o_ready), RW'(1));
    compare("rst_o_ovf",   RW'(o_ovf),   RW'(0));
    for (int c = 0; c < COL; c++) colQ[c].delete();
    expQ.delete();
    lastRow = '0;
    modelOvf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: a pop happens when rd meets o_valid; check the registered row after the edge.
  initial begin
    bit pend;
    forever begin
      @(negedge clk);
      #2;
      pend = rd && o_valid && reset;
      @(posedge clk);
      #1;
      if (pend) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_pop: got %h expected no pop", out);
        end else begin
          compare("row", out, expQ.pop_front());
        end
      end
    end
  end

  // Directed phases followed by a randomized stream.
  initial begin
    logic [RW-1:0] d;
    logic [COL-1:0] w;
    #2;
    compare("init_out",     out, '0);
    compare("init_o_valid", RW'(o_valid), RW'(0));
    compare("init_o_ready", RW'(o_ready), RW'(1));
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-fill with three entries in col0.
    for (int i = 0; i < 3; i++) applyStimulus(8'h01, randRow(), 1'b0);
    resetDut();

    // Skewed fill: o_valid rises only after col7 is written.
    for (int c = 0; c < COL; c++) d[c*BW +: BW] = BW'(16'h1000 + c);
    for (int k = 0; k < COL; k++) applyStimulus(COL'((1 << (k + 1)) - 1), d, 1'b0);
    applyStimulus('0, '0, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus('0, '0, 1'b1);

    // Alignment: column c delayed c cycles, values r*16+c.
    resetDut();
    for (int t = 0; t < 10; t++) begin
      w = '0;
      d = '0;
      for (int c = 0; c < COL; c++) begin
        if (t >= c && t < c + 3) begin
          w[c] = 1'b1;
          d[c*BW +: BW] = BW'((t - c) * 16 + c);
        end
      end
      applyStimulus(w, d, 1'b0);
    end
    for (int i = 0; i < 4; i++) applyStimulus('0, '0, 1'b1);

    // Full and overflow on col2, then verify its contents by draining.
    resetDut();
    for (int i = 0; i < 17; i++) applyStimulus(8'h04, randRow(), 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(8'hFB, randRow(), 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus('0, '0, 1'b1);

    // Read while empty is ignored.
    applyStimulus('0, '0, 1'b1);
    applyStimulus('0, '0, 1'b1);

    // All columns full: same-cycle pop and write, write dropped.
    resetDut();
    for (int i = 0; i < DEPTH; i++) applyStimulus('1, randRow(), 1'b0);
    applyStimulus('1, randRow(), 1'b1);
    applyStimulus('0, '0, 1'b0);
    applyStimulus('1, randRow(), 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus('0, '0, 1'b1);

    // Wrap-around: one row preloaded, then concurrent push/pop.
    resetDut();
    applyStimulus('1, randRow(), 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus('1, randRow(), 1'b1);
    applyStimulus('0, '0, 1'b1);
    applyStimulus('0, '0, 1'b0);

    // Random traffic with a reset in the middle.
    resetDut();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) resetDut();
      w = COL'($urandom) | COL'($urandom);
      applyStimulus(w, randRow(), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus('0, '0, 1'b1);
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    compare("scoreboard_left", RW'(expQ.size()), RW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
